// File: rtl/updown_sweep_ctrl.sv
// Command-driven sequencer over a 3-bit up/down counter with terminal-count detection.
// Runs UP, DOWN or BOUNCE sweeps for a programmed number of terminal-count passes.
module updown_sweep_ctrl #(
    parameter int unsigned PASS_W = 4
) (
    input  logic              clk,
    input  logic              clrbar,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_mode,
    input  logic [PASS_W-1:0] cmd_passes,
    input  logic              hold,
    input  logic              abort,
    output logic [2:0]        q,
    output logic              dir,
    output logic              tc,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [PASS_W-1:0] passes_left
);

    localparam int unsigned Q_W = 3;
    localparam logic [1:0] MODE_DOWN   = 2'b01;
    localparam logic [1:0] MODE_BOUNCE = 2'b10;
    localparam logic [1:0] MODE_BAD    = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [Q_W-1:0]    q_q, q_d;
    logic              dir_q, dir_d;
    logic [PASS_W-1:0] passes_q, passes_d;
    logic              bounce_q, bounce_d;
    logic              err_d;
    logic              term;

    assign term = dir_q ? (q_q == '1) : (q_q == '0);
    assign tc   = (state_q == RUN) & term & ~hold & ~abort;

    // State and datapath registers; status flags are registered from the next state
    always_ff @(posedge clk or negedge clrbar) begin
        if (!clrbar) begin
            state_q   <= IDLE;
            q_q       <= '0;
            dir_q     <= 1'b1;
            passes_q  <= '0;
            bounce_q  <= 1'b0;
            err       <= 1'b0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state_q   <= state_d;
            q_q       <= q_d;
            dir_q     <= dir_d;
            passes_q  <= passes_d;
            bounce_q  <= bounce_d;
            err       <= err_d;
            cmd_ready <= (state_d == IDLE);
            busy      <= (state_d != IDLE);
            done      <= (state_d == DONE);
        end
    end

    // Next-state and counter update
    always_comb begin
        state_d  = state_q;
        q_d      = q_q;
        dir_d    = dir_q;
        passes_d = passes_q;
        bounce_d = bounce_q;
        err_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    if ((cmd_mode != MODE_BAD) && (cmd_passes != '0)) begin
                        state_d  = RUN;
                        passes_d = cmd_passes;
                        bounce_d = (cmd_mode == MODE_BOUNCE);
                        if (cmd_mode == MODE_DOWN) begin
                            q_d   = '1;
                            dir_d = 1'b0;
                        end else begin
                            q_d   = '0;
                            dir_d = 1'b1;
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (abort) begin
                    state_d  = IDLE;
                    q_d      = '0;
                    dir_d    = 1'b1;
                    passes_d = '0;
                end else if (!hold) begin
                    if (term && (passes_q == PASS_W'(1))) begin
                        passes_d = '0;
                        state_d  = DONE;
                    end else begin
                        // A plain step in the (possibly reversed) direction gives wrap or bounce
                        if (term) begin
                            passes_d = passes_q - PASS_W'(1);
                            if (bounce_q) begin
                                dir_d = ~dir_q;
                            end
                        end
                        q_d = dir_d ? (q_q + Q_W'(1)) : (q_q - Q_W'(1));
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign q           = q_q;
    assign dir         = dir_q;
    assign passes_left = passes_q;

endmodule
